imuldiv_div_requester: RTL and testbench

- Initiator side of the divider request/response interface.
- Accepts single-issue DIV/DIVU/REM/REMU operations tagged with a destination register from the execute stage.
- Issues each operation to the iterative divider and consumes its 64-bit {remainder, quotient} response.
- Returns the selected 32-bit word with its tag on a writeback val/rdy port. Divide-by-zero is resolved locally without engaging the divider.

---
 rtl/imuldiv_div_requester.sv | 82 ++++++++
 tb/tb_imuldiv_div_requester.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/imuldiv_div_requester.sv
// Divider request/response initiator: issues DIV/DIVU/REM/REMU to an iterative
// divider, resolves divide-by-zero locally, and returns the selected word with its tag.
module imuldiv_div_requester #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             op_val,
  output logic             op_rdy,
  input  logic [1:0]       op_fn,
  input  logic [31:0]      op_a,
  input  logic [31:0]      op_b,
  input  logic [TAG_W-1:0] op_tag,

  output logic             divreq_msg_fn,
  output logic [31:0]      divreq_msg_a,
  output logic [31:0]      divreq_msg_b,
  output logic             divreq_val,
  input  logic             divreq_rdy,

  input  logic [63:0]      divresp_msg_result,
  input  logic             divresp_val,
  output logic             divresp_rdy,

  output logic             wb_val,
  input  logic             wb_rdy,
  output logic [31:0]      wb_data,
  output logic [TAG_W-1:0] wb_tag
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic [1:0]       fn;
  logic [31:0]      a, b, result;
  logic [TAG_W-1:0] tag;
  logic             op_go, div_by_zero;

  assign op_go       = (state == IDLE) && op_val;
  assign div_by_zero = (op_b == 32'd0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (op_val)      state_nxt = div_by_zero ? RESP : REQ;
      REQ:     if (divreq_rdy)  state_nxt = WAIT;
      WAIT:    if (divresp_val) state_nxt = RESP;
      RESP:    if (wb_rdy)      state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Divide-by-zero follows RISC-V: quotient all ones, remainder is the dividend.
  always_ff @(posedge clk) begin
    if (op_go) begin
      fn  <= op_fn;
      a   <= op_a;
      b   <= op_b;
      tag <= op_tag;
      if (div_by_zero) result <= op_fn[1] ? op_a : 32'hFFFF_FFFF;
    end else if (state == WAIT && divresp_val) begin
      result <= fn[1] ? divresp_msg_result[63:32] : divresp_msg_result[31:0];
    end
  end

  assign op_rdy        = (state == IDLE);
  assign divreq_val    = (state == REQ);
  assign divresp_rdy   = (state == WAIT);
  assign wb_val        = (state == RESP);
  assign divreq_msg_fn = ~fn[0];
  assign divreq_msg_a  = a;
  assign divreq_msg_b  = b;
  assign wb_data       = result;
  assign wb_tag        = tag;

endmodule

// File: tb/tb_imuldiv_div_requester.sv
// Scoreboard bench: random/directed ops, a behavioural divider on the request side,
// and an independent writeback monitor popping expected results.
module tb_imuldiv_div_requester;
  localparam int TAG_W = 5;

  logic             clk, reset;
  logic             op_val, op_rdy;
  logic [1:0]       op_fn;
  logic [31:0]      op_a, op_b;
  logic [TAG_W-1:0] op_tag;
  logic             divreq_msg_fn, divreq_val, divreq_rdy;
  logic [31:0]      divreq_msg_a, divreq_msg_b;
  logic [63:0]      divresp_msg_result;
  logic             divresp_val, divresp_rdy;
  logic             wb_val, wb_rdy;
  logic [31:0]      wb_data;
  logic [TAG_W-1:0] wb_tag;

  imuldiv_div_requester #(.TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .op_val(op_val), .op_rdy(op_rdy), .op_fn(op_fn), .op_a(op_a), .op_b(op_b), .op_tag(op_tag),
    .divreq_msg_fn(divreq_msg_fn), .divreq_msg_a(divreq_msg_a), .divreq_msg_b(divreq_msg_b),
    .divreq_val(divreq_val), .divreq_rdy(divreq_rdy),
    .divresp_msg_result(divresp_msg_result), .divresp_val(divresp_val), .divresp_rdy(divresp_rdy),
    .wb_val(wb_val), .wb_rdy(wb_rdy), .wb_data(wb_data), .wb_tag(wb_tag)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  int pass_cnt = 0, total_cnt = 0;
  int req_count = 0, wb_count = 0;
  int lat_force = -1, req_hold = 0, wb_hold = 0;
  logic [TAG_W+31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
  endtask

  // {remainder, quotient} with plain arithmetic; overflow case pinned explicitly.
  function automatic logic [63:0] divide(input logic sgn, input logic [31:0] x, input logic [31:0] y);
    logic signed [31:0] sx, sy;
    logic [31:0] q, r;
    sx = x; sy = y;
    if (y == 32'd0) return 64'hDEAD_BEEF_DEAD_BEEF;
    if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin q = x; r = 32'd0; end
    else if (sgn) begin q = sx / sy; r = sx % sy; end
    else begin q = x / y; r = x % y; end
    return {r, q};
  endfunction

  function automatic logic [31:0] ref_res(input logic [1:0] fn, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] d;
    if (y == 32'd0) return fn[1] ? x : 32'hFFFF_FFFF;
    d = divide(~fn[0], x, y);
    return fn[1] ? d[63:32] : d[31:0];
  endfunction

  // Behavioural iterative divider with random acceptance and latency.
  initial begin
    logic        pending, req_fire, resp_fire, req_seen;
    logic [63:0] dres;
    logic [31:0] pa, pb;
    logic        pfn;
    int          cnt;
    divreq_rdy = 0; divresp_val = 0; divresp_msg_result = '0;
    pending = 0; req_fire = 0; resp_fire = 0; req_seen = 0; cnt = 0; dres = '0;
    pa = '0; pb = '0; pfn = 0;
    forever begin
      @(negedge clk); #1;
      if (resp_fire) begin divresp_val = 0; pending = 0; end
      if (req_fire) begin pending = 1; cnt = (lat_force >= 0) ? lat_force : $urandom_range(0, 4); end
      if (req_seen) begin
        check("req_val_held", 64'(divreq_val), 64'd1);
        check("req_ops_held", {31'd0, divreq_msg_fn, divreq_msg_a}, {31'd0, pfn, pa});
        check("req_b_held", 64'(divreq_msg_b), 64'(pb));
      end
      if (reset) begin pending = 0; divresp_val = 0; end
      else if (pending && !divresp_val) begin
        if (cnt == 0) begin divresp_val = 1; divresp_msg_result = dres; end
        else cnt--;
      end
      if (divreq_val && req_hold > 0) begin req_hold--; divreq_rdy = 0; end
      else divreq_rdy = !pending && ($urandom_range(0, 3) != 0);
      req_fire = divreq_val && divreq_rdy && !reset;
      if (req_fire) begin dres = divide(divreq_msg_fn, divreq_msg_a, divreq_msg_b); req_count++; end
      req_seen = divreq_val && !req_fire && !reset;
      pa = divreq_msg_a; pb = divreq_msg_b; pfn = divreq_msg_fn;
      resp_fire = divresp_val && divresp_rdy && !reset;
    end
  end

  // Writeback monitor: random backpressure, stability and scoreboard compare.
  initial begin
    logic              wb_fire, wb_seen;
    logic [31:0]       pd;
    logic [TAG_W-1:0]  pt;
    logic [TAG_W+31:0] e;
    wb_rdy = 0; wb_fire = 0; wb_seen = 0; pd = '0; pt = '0;
    forever begin
      @(negedge clk); #1;
      if (wb_seen) begin
        check("wb_val_held", 64'(wb_val), 64'd1);
        check("wb_data_held", 64'(wb_data), 64'(pd));
        check("wb_tag_held", 64'(wb_tag), 64'(pt));
      end
      if (wb_val && wb_hold > 0) begin wb_hold--; wb_rdy = 0; end
      else wb_rdy = ($urandom_range(0, 3) != 0);
      wb_fire = wb_val && wb_rdy && !reset;
      if (wb_fire) begin
        wb_count++;
        if (exp_q.size() == 0) check("wb_extra", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          check("wb_data", 64'(wb_data), 64'(e[31:0]));
          check("wb_tag", 64'(wb_tag), 64'(e[TAG_W+31:32]));
        end
      end
      wb_seen = wb_val && !wb_fire && !reset;
      pd = wb_data; pt = wb_tag;
    end
  end

  task automatic issue(input logic [1:0] fn, input logic [31:0] x, input logic [31:0] y,
                       input logic [TAG_W-1:0] tg);
    int n = 0;
    op_val = 1; op_fn = fn; op_a = x; op_b = y; op_tag = tg;
    while (!op_rdy && n < 300) begin @(negedge clk); n++; end
    if (!op_rdy) begin check("accept_timeout", 64'd0, 64'd1); op_val = 0; return; end
    exp_q.push_back({tg, ref_res(fn, x, y)});
    @(negedge clk);
    op_val = 0; op_a = $urandom; op_b = $urandom; op_tag = '0;
    if (y == 32'd0) check("dz_wb_next_cycle", {wb_val, divreq_val}, 64'b10);
    else            check("req_next_cycle", {wb_val, divreq_val}, 64'b01);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || !op_rdy) && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) check("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int rc, wc, n;
    logic [31:0] x, y;
    reset = 1; op_val = 0; op_fn = '0; op_a = '0; op_b = '0; op_tag = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {op_rdy, divreq_val, divresp_rdy, wb_val}, 64'b1000);
    reset = 0;
    @(negedge clk);

    issue(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3);  wait_idle();
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd4);  wait_idle();
    issue(2'b11, 32'hFFFF_FFF9, 32'd2, 5'd5);  wait_idle();

    rc = req_count;
    issue(2'b01, 32'd100, 32'd0, 5'd6);
    issue(2'b11, 32'd100, 32'd0, 5'd7);
    wait_idle();
    check("dz_no_divreq", 64'(req_count - rc), 64'd0);

    issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    wait_idle();

    // Long request and writeback stalls on a single op.
    wc = wb_count; rc = req_count;
    req_hold = 5; wb_hold = 4;
    issue(2'b01, 32'd1000, 32'd7, 5'd10);
    n = 0;
    while (wb_count == wc && n < 200) begin
      check("op_rdy_low_busy", 64'(op_rdy), 64'd0);
      @(negedge clk); n++;
    end
    check("op_rdy_after_wb", 64'(op_rdy), 64'd1);
    repeat (3) @(negedge clk);
    check("stall_one_wb", 64'(wb_count - wc), 64'd1);
    check("stall_one_req", 64'(req_count - rc), 64'd1);
    wait_idle();

    // Reset while the divider is still working.
    lat_force = 30;
    issue(2'b01, 32'd50, 32'd5, 5'd11);
    n = 0;
    while (!divresp_rdy && n < 100) begin @(negedge clk); n++; end
    check("reached_wait", 64'(divresp_rdy), 64'd1);
    reset = 1; exp_q.delete();
    @(negedge clk);
    reset = 0;
    check("mid_reset_outputs", {op_rdy, divreq_val, divresp_rdy, wb_val}, 64'b1000);
    lat_force = -1;
    issue(2'b01, 32'd9, 32'd3, 5'd12);
    wait_idle();

    // Random back-to-back traffic.
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0:       begin x = $urandom; y = 32'd0; end
        1:       begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2, 3:    begin x = $urandom_range(0, 300) - 150; y = $urandom_range(0, 20) - 10; end
        default: begin x = $urandom; y = $urandom >> $urandom_range(0, 31); end
      endcase
      issue(2'($urandom_range(0, 3)), x, y, TAG_W'($urandom));
    end
    wait_idle();
    repeat (5) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired: passed=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule
